// File: rtl/vc_demux_sched_pkg.sv
// Shared definitions for the VC scheduler: FSM state encoding and parameter defaults.
package vc_demux_sched_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    localparam int DATA_W_DFLT   = 8;
    localparam int DEPTH_DFLT    = 8;
    localparam int LVL_W_DFLT    = 4;
    localparam int DEST_BIT_DFLT = 7;
    localparam int WEIGHT0_DFLT  = 3;
    // Leaves room for the scheduler register, demux register and level update latency.
    localparam int THR_RST_DFLT  = 5;

endpackage

// File: rtl/vc_demux_sched_if.sv
// Datapath bundle between the VC FIFO pair, the scheduler and the class demux.
interface vc_demux_sched_if
    import vc_demux_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int LVL_W  = LVL_W_DFLT
);

    logic              vc0_empty;
    logic              vc1_empty;
    logic [DATA_W-1:0] vc0_data;
    logic [DATA_W-1:0] vc1_data;
    logic              vc0_pop;
    logic              vc1_pop;
    logic [LVL_W-1:0]  d0_level;
    logic [LVL_W-1:0]  d1_level;
    logic [DATA_W-1:0] data_out;
    logic              classif;
    logic              valid;

    modport master (
        input  vc0_empty, vc1_empty, vc0_data, vc1_data, d0_level, d1_level,
        output vc0_pop, vc1_pop, data_out, classif, valid
    );

    modport slave (
        output vc0_empty, vc1_empty, vc0_data, vc1_data, d0_level, d1_level,
        input  vc0_pop, vc1_pop, data_out, classif, valid
    );

endinterface

// File: rtl/vc_demux_sched_wrr_arbiter2.sv
// Two-input weighted round-robin arbiter: requester 0 gets up to WEIGHT grants
// in a row while requester 1 waits, then requester 1 gets one.
module wrr_arbiter2
    import vc_demux_sched_pkg::*;
#(
    parameter int WEIGHT = WEIGHT0_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    localparam int CNT_W = (WEIGHT > 0) ? $clog2(WEIGHT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WEIGHT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every output of a combinational block gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        cnt_d  = cnt_q;
        if (req0_i && (!req1_i || cnt_q < CNT_MAX)) begin
            gnt0_o = 1'b1;
            if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (req1_i) begin
            gnt1_o = 1'b1;
            cnt_d  = '0;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vc_demux_sched.sv
// Scheduler feeding the 1:2 class demux from two FWFT VC FIFOs, holding back
// words whose destination FIFO has reached its almost-full threshold.
module vc_demux_sched
    import vc_demux_sched_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DFLT,
    parameter int DEPTH    = DEPTH_DFLT,
    parameter int LVL_W    = LVL_W_DFLT,
    parameter int DEST_BIT = DEST_BIT_DFLT,
    parameter int WEIGHT0  = WEIGHT0_DFLT,
    parameter int THR_RST  = THR_RST_DFLT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [LVL_W-1:0] thr0,
    input  logic [LVL_W-1:0] thr1,
    vc_demux_sched_if.master bus,
    output logic             idle_out,
    output logic             error_out
);

    localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] THR_RST_L = LVL_W'(THR_RST);

    state_e            state_q, state_d;
    logic [LVL_W-1:0]  thr0_q, thr1_q;
    logic [DATA_W-1:0] data_q, data_d;
    logic              classif_q, classif_d;
    logic              valid_q, valid_d;
    logic              idle_q, idle_d;
    logic              error_q, error_d;

    logic lvl_err;
    logic arb_en;
    logic elig0, elig1;
    logic gnt0, gnt1;

    assign lvl_err = (bus.d0_level > DEPTH_L) || (bus.d1_level > DEPTH_L);
    assign arb_en  = (state_q == ST_IDLE || state_q == ST_ACTIVE) && !init && !lvl_err;

    // A head is eligible only if the FIFO its destination bit points at is below threshold.
    assign elig0 = arb_en && !bus.vc0_empty &&
                   (bus.vc0_data[DEST_BIT] ? (bus.d1_level < thr1_q) : (bus.d0_level < thr0_q));
    assign elig1 = arb_en && !bus.vc1_empty &&
                   (bus.vc1_data[DEST_BIT] ? (bus.d1_level < thr1_q) : (bus.d0_level < thr0_q));

    wrr_arbiter2 #(
        .WEIGHT (WEIGHT0)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req0_i (elig0),
        .req1_i (elig1),
        .gnt0_o (gnt0),
        .gnt1_o (gnt1)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (lvl_err)    state_d = ST_ERROR;
                else if (!init) state_d = ST_IDLE;
            end
            ST_IDLE, ST_ACTIVE: begin
                if (lvl_err)            state_d = ST_ERROR;
                else if (init)          state_d = ST_INIT;
                else if (gnt0 || gnt1)  state_d = ST_ACTIVE;
                else                    state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (init && !lvl_err) state_d = ST_INIT;
            end
            default: state_d = ST_RESET;
        endcase

        valid_d   = gnt0 || gnt1;
        data_d    = data_q;
        classif_d = classif_q;
        if (gnt0) begin
            data_d    = bus.vc0_data;
            classif_d = bus.vc0_data[DEST_BIT];
        end else if (gnt1) begin
            data_d    = bus.vc1_data;
            classif_d = bus.vc1_data[DEST_BIT];
        end

        // Status flags are registered from the next state so they line up with it.
        idle_d  = (state_d == ST_IDLE) && bus.vc0_empty && bus.vc1_empty;
        error_d = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RESET;
            thr0_q    <= THR_RST_L;
            thr1_q    <= THR_RST_L;
            data_q    <= '0;
            classif_q <= 1'b0;
            valid_q   <= 1'b0;
            idle_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (state_q == ST_INIT) begin
                thr0_q <= thr0;
                thr1_q <= thr1;
            end
            data_q    <= data_d;
            classif_q <= classif_d;
            valid_q   <= valid_d;
            idle_q    <= idle_d;
            error_q   <= error_d;
        end
    end

    assign bus.vc0_pop  = gnt0;
    assign bus.vc1_pop  = gnt1;
    assign bus.data_out = data_q;
    assign bus.classif  = classif_q;
    assign bus.valid    = valid_q;
    assign idle_out     = idle_q;
    assign error_out    = error_q;

endmodule
